// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer around one full-adder cell
//
// Latches two WIDTH-bit operands on an accepted start, then feeds one bit per
// clock (LSB first) through a full adder with a registered carry. The result
// appears after exactly WIDTH clocks together with a one-cycle done pulse.
//
// Optional feature macro: SERIAL_ADD_OVF_EN (adds the ovf output).
//
// Ports:
//   clk    in             system clock, rising edge
//   rst    in             synchronous active-high reset
//   start  in             request, sampled only while ready=1
//   a, b   in  [WIDTH]    operands, captured on the accepting edge
//   ci     in             carry-in, ignored when sub=1
//   sub    in             1 = compute a + ~b + 1
//   ready  out            idle or done; a start is accepted this cycle
//   busy   out            serial computation in progress
//   done   out            one-cycle pulse, S/cout valid
//   S      out [WIDTH]    result, held until next completion or reset
//   cout   out            carry out of the MSB (sub=1: 1 = no borrow)
//   ovf    out            two's-complement overflow (SERIAL_ADD_OVF_EN only)

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [CW-1:0]    cnt;
    // Holds the WIDTH-1 sum bits produced so far; the final bit is joined
    // directly from the adder on the completing edge.
    logic [WIDTH-2:0] acc;

    logic             accept;
    logic             last;
    logic             s_bit;
    logic             c_nxt;
    logic [WIDTH-1:0] shin;

    assign last  = (cnt == CW'(WIDTH - 1));
    assign s_bit = opa[0] ^ opb[0] ^ carry;
    assign c_nxt = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
    assign shin  = {s_bit, acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                // Back-to-back accept skips the idle bubble.
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            S     <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            opa   <= a;
            // Subtraction is a + ~b with the carry-in forced to 1.
            opb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : ci;
            cnt   <= '0;
            acc   <= '0;
        end else if (state == RUN) begin
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            carry <= c_nxt;
            acc   <= shin[WIDTH-1:1];
            cnt   <= cnt + CW'(1);
            if (last) begin
                S    <= shin;
                cout <= c_nxt;
`ifdef SERIAL_ADD_OVF_EN
                // carry is the carry into the MSB on this final step.
                ovf  <= carry ^ c_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl

module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         sub = 1'b0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .sub   (sub),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .S     (S),
`ifdef SERIAL_ADD_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: full-width sum including carry out.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic s);
        logic [W-1:0] yy;
        yy = s ? ~y : y;
        return {1'b0, x} + {1'b0, yy} + (W+1)'(s ? 1'b1 : c);
    endfunction

    // Signed overflow: same-sign operands yielding an opposite-sign result.
    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic c, input logic s);
        logic [W-1:0] yy;
        logic [W:0]   r;
        yy = s ? ~y : y;
        r  = ref_sum(x, y, c, s);
        return (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    // Transaction-level model: an accepted op completes WIDTH edges later.
    int         edge_n = 0;
    int         m_due = 0;
    logic       m_valid = 1'b0;
    logic       m_pending = 1'b0;
    logic       m_done = 1'b0;
    logic [W:0] m_res = '0;
    logic       m_rovf = 1'b0;
    logic [W-1:0] m_s = '0;
    logic       m_cout = 1'b0;
    logic       m_ovf = 1'b0;

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (rst) begin
            m_valid   <= 1'b1;
            m_pending <= 1'b0;
            m_done    <= 1'b0;
            m_s       <= '0;
            m_cout    <= 1'b0;
            m_ovf     <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_pending && edge_n == m_due) begin
                m_pending <= 1'b0;
                m_done    <= 1'b1;
                m_s       <= m_res[W-1:0];
                m_cout    <= m_res[W];
                m_ovf     <= m_rovf;
            end else if (!m_pending && start) begin
                m_pending <= 1'b1;
                m_due     <= edge_n + W;
                m_res     <= ref_sum(a, b, ci, sub);
                m_rovf    <= ref_ovf(a, b, ci, sub);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ready", 32'(ready), 32'(!m_pending));
            chk("busy",  32'(busy),  32'(m_pending));
            chk("done",  32'(done),  32'(m_done));
            chk("S",     32'(S),     32'(m_s));
            chk("cout",  32'(cout),  32'(m_cout));
`ifdef SERIAL_ADD_OVF_EN
            chk("ovf",   32'(ovf),   32'(m_ovf));
`endif
        end
    end

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= W + 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xc, input logic xs,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        a = xa; b = xb; ci = xc; sub = xs; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~xa; b = ~xb; ci = ~xc; sub = ~xs;
        wait_done(lat);
        chk({name, "_latency"}, 32'(lat), 32'(W));
        chk({name, "_S"}, 32'(S), 32'(es));
        chk({name, "_cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
        chk({name, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo !== 1'bx) begin end
`endif
    endtask

    initial begin
        int lat;
        logic saw_done;
        logic [W-1:0] pick [5];

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_done",  32'(done),  32'd0);
        chk("reset_S",     32'(S),     32'd0);
        chk("reset_cout",  32'(cout),  32'd0);

        do_op("add_3c_5a",  8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        do_op("add_ff_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op("add_cin",    8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
        do_op("sub_10_01",  8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0);
        do_op("sub_01_02",  8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        do_op("ovf_7f_01",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op("ovf_80_ff",  8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1);
        do_op("ovf_01_01",  8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

        // start held through RUN, then accepted again in the DONE cycle
        @(negedge clk);
        a = 8'h3C; b = 8'h5A; ci = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h01; b = 8'h01;
        wait_done(lat);
        chk("hold_latency", 32'(lat), 32'(W));
        chk("hold_S", 32'(S), 32'h96);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_no_idle", 32'(busy), 32'd1);
        wait_done(lat);
        chk("b2b_latency", 32'(lat), 32'(W));
        chk("b2b_S", 32'(S), 32'h02);

        // reset in the fourth RUN cycle aborts without a done
        @(negedge clk);
        a = 8'h3C; b = 8'h5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",  32'(busy),  32'd0);
        chk("abort_done",  32'(done),  32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_S",     32'(S),     32'd0);
        chk("abort_cout",  32'(cout),  32'd0);
        saw_done = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);

        // randomized traffic with corner operands and occasional reset
        pick[0] = 8'h00; pick[1] = 8'hFF; pick[2] = 8'h7F; pick[3] = 8'h80;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) != 0);
            pick[4] = W'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : W'($urandom);
            pick[4] = W'($urandom);
            b   = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : pick[4];
            ci  = 1'($urandom);
            sub = 1'($urandom);
            rst = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        repeat (W + 3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
